// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for one elastic pipeline stage: upstream valid/ready/data,
// downstream valid/ready/data, the flush control and the stall counter readout.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 174,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic [0:WIDTH-1]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [0:WIDTH-1]   out_data;
    logic               out_ready;
    logic               flush;
    logic [CNT_W-1:0]   stall_cnt;

    // master: the surrounding pipeline (producer, consumer, flush control)
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, stall_cnt
    );

    // slave: the stage register itself
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: main register plus one skid entry, so back-pressure
// never reaches in_ready combinationally. Flush inserts a bubble; stall_cnt counts stalls.
module pipe_skid_reg #(
    parameter int WIDTH          = 174,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_skid_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               r_main_v;
    logic               r_skid_v;
    logic [0:WIDTH-1]   r_main_d;
    logic [0:WIDTH-1]   r_skid_d;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_accept;
    logic               w_take;
    logic               w_stall;
    logic               w_illegal;

    assign w_accept  = bus.in_valid & ~r_skid_v;
    assign w_take    = r_main_v & bus.out_ready;
    assign w_stall   = r_main_v & ~bus.out_ready;
    // A skid entry without a main entry can only come from an upset; recover like reset.
    assign w_illegal = ~r_main_v & r_skid_v;

    always_ff @(posedge clk) begin
        if (reset || w_illegal) begin
            r_main_v    <= 1'b0;
            r_skid_v    <= 1'b0;
            r_main_d    <= '0;
            r_skid_d    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;

            if (bus.flush) begin
                // A take in this cycle has already completed downstream; only held state dies.
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
                if (CLEAR_ON_FLUSH) begin
                    r_main_d <= '0;
                    r_skid_d <= '0;
                end
            end else begin
                case ({r_main_v, r_skid_v})
                    2'b00: begin
                        if (w_accept) begin
                            r_main_d <= bus.in_data;
                            r_main_v <= 1'b1;
                        end
                    end
                    2'b10: begin
                        if (w_accept && w_take) begin
                            r_main_d <= bus.in_data;
                        end else if (w_accept) begin
                            r_skid_d <= bus.in_data;
                            r_skid_v <= 1'b1;
                        end else if (w_take) begin
                            r_main_v <= 1'b0;
                        end
                    end
                    2'b11: begin
                        if (w_take) begin
                            r_main_d <= r_skid_d;
                            r_skid_v <= 1'b0;
                        end
                    end
                    default: begin
                        r_main_v <= 1'b0;
                        r_skid_v <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = ~r_skid_v;
    assign bus.out_valid = r_main_v;
    assign bus.out_data  = r_main_d;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two instances share stimulus (4-bit counter with clear-on-flush,
// 16-bit counter with hold-on-flush); a queue scoreboard tracks accepted bundles.
module tb_pipe_skid_reg;
    localparam int W = 174;

    logic           clk;
    logic           rst;
    logic           tb_in_valid;
    logic [W-1:0]   tb_in_data;
    logic           tb_out_ready;
    logic           tb_flush;

    int             n_cmp;
    int             n_err;
    logic [W-1:0]   sb[$];
    logic [3:0]     stall4;
    logic [15:0]    stall16;

    pipe_skid_reg_if #(.WIDTH(W), .CNT_W(4))  if0 ();
    pipe_skid_reg_if #(.WIDTH(W), .CNT_W(16)) if1 ();

    assign if0.in_valid  = tb_in_valid;
    assign if0.in_data   = tb_in_data;
    assign if0.out_ready = tb_out_ready;
    assign if0.flush     = tb_flush;
    assign if1.in_valid  = tb_in_valid;
    assign if1.in_data   = tb_in_data;
    assign if1.out_ready = tb_out_ready;
    assign if1.flush     = tb_flush;

    pipe_skid_reg #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) u_dut_clr (
        .clk   (clk),
        .reset (rst),
        .bus   (if0.slave)
    );

    pipe_skid_reg #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) u_dut_hold (
        .clk   (clk),
        .reset (rst),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r = (r << 32) | W'($urandom());
        return r;
    endfunction

    // One clock cycle: drive at posedge+1, check and update the model at negedge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        logic         exp_rdy;
        logic         exp_ov;
        logic [W-1:0] exp_d;
        tb_in_valid  = iv;
        tb_in_data   = d;
        tb_out_ready = ordy;
        tb_flush     = fl;
        @(negedge clk);
        exp_rdy = (sb.size() < 2);
        exp_ov  = (sb.size() > 0);
        check("in_ready", {255'd0, if0.in_ready}, {255'd0, exp_rdy});
        check("out_valid", {255'd0, if0.out_valid}, {255'd0, exp_ov});
        check("out_valid_hold", {255'd0, if1.out_valid}, {255'd0, exp_ov});
        check("stall_cnt4", {252'd0, if0.stall_cnt}, {252'd0, stall4});
        check("stall_cnt16", {240'd0, if1.stall_cnt}, {240'd0, stall16});
        if (exp_ov && !ordy) begin
            if (stall4 != 4'hF) stall4 = stall4 + 4'd1;
            if (stall16 != 16'hFFFF) stall16 = stall16 + 16'd1;
        end
        if (exp_ov && ordy) begin
            exp_d = sb.pop_front();
            $display("take: out_data %h", if0.out_data[W-32:W-1]);
            check("out_data", {82'd0, if0.out_data}, {82'd0, exp_d});
            check("out_data_hold", {82'd0, if1.out_data}, {82'd0, exp_d});
        end
        if (fl) sb.delete();
        else if (iv && exp_rdy) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst          = 1'b1;
        tb_in_valid  = 1'b1;
        tb_in_data   = '1;
        tb_out_ready = 1'b0;
        tb_flush     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_in_ready", {255'd0, if0.in_ready}, 256'd1);
        check("rst_out_valid", {255'd0, if0.out_valid}, 256'd0);
        check("rst_out_data", {82'd0, if0.out_data}, 256'd0);
        check("rst_out_data_hold", {82'd0, if1.out_data}, 256'd0);
        check("rst_stall4", {252'd0, if0.stall_cnt}, 256'd0);
        check("rst_stall16", {240'd0, if1.stall_cnt}, 256'd0);
        rst = 1'b0;
        sb.delete();
        stall4  = '0;
        stall16 = '0;
    endtask

    initial begin
        logic [W-1:0] a, b, c, d1, d2, d3;
        n_cmp   = 0;
        n_err   = 0;
        stall4  = '0;
        stall16 = '0;

        do_reset(2);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Skid: A accepted, stall from B onward, C refused until the skid drains
        a = rnd_data(); b = rnd_data(); c = rnd_data();
        cycle(1'b1, a, 1'b1, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, c, 1'b0, 1'b0);
        cycle(1'b1, c, 1'b1, 1'b0);
        cycle(1'b1, c, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        check("skid_stall_total", {240'd0, if1.stall_cnt}, 256'd4);

        // Flush while two are held, with a bundle offered in the flush cycle
        d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
        cycle(1'b1, d1, 1'b0, 1'b0);
        cycle(1'b1, d2, 1'b0, 1'b0);
        cycle(1'b1, d3, 1'b0, 1'b1);
        check("flush_out_data_clr", {82'd0, if0.out_data}, 256'd0);
        check("flush_out_data_hold", {82'd0, if1.out_data}, {82'd0, d1});
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in ONE: the take completes, the incoming bundle is discarded
        cycle(1'b1, rnd_data(), 1'b1, 1'b0);
        cycle(1'b1, rnd_data(), 1'b1, 1'b1);
        cycle(1'b1, rnd_data(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Counter saturation on the 4-bit instance, then flush, then reset
        cycle(1'b1, rnd_data(), 1'b0, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
        check("sat_stall4", {252'd0, if0.stall_cnt}, 256'd15);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("sat_after_flush", {252'd0, if0.stall_cnt}, 256'd15);
        do_reset(1);

        // Random valid/ready traffic
        for (int i = 0; i < 100; i++)
            cycle(1'($urandom_range(0, 1)), rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
        check("drained", 256'(sb.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
